// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - CPU, DMA and memory bus bundle for the memory arbiter
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_data_out;
  logic              cpu_READ_write;
  logic [DATA_W-1:0] cpu_data_in;
  logic              cpu_rdy;

  logic              dma_req;
  logic [ADDR_W-1:0] dma_address;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_we;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_wrt_en;
  logic [DATA_W-1:0] mem_data_out;

  // Arbiter side: drives the memory port and the CPU/DMA responses
  modport master (
    input  cpu_address, cpu_data_out, cpu_READ_write,
    output cpu_data_in, cpu_rdy,
    input  dma_req, dma_address, dma_wdata, dma_we,
    output dma_ack, dma_rdata,
    output mem_address, mem_data_in, mem_wrt_en,
    input  mem_data_out
  );

  // Environment side: CPU core, DMA master and memory block
  modport slave (
    output cpu_address, cpu_data_out, cpu_READ_write,
    input  cpu_data_in, cpu_rdy,
    output dma_req, dma_address, dma_wdata, dma_we,
    input  dma_ack, dma_rdata,
    input  mem_address, mem_data_in, mem_wrt_en,
    output mem_data_out
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fixed-priority CPU/DMA memory arbiter with DMA burst limit
module mem_bus_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.master  bus
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    CPU_OWN   = 2'd0,
    DMA_BURST = 2'd1,
    HANDBACK  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  // Registered decode of state==DMA_BURST, kept in lockstep with state
  logic             dma_own;

  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              we_mux;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CPU_OWN;
      count   <= '0;
      dma_own <= 1'b0;
    end else begin
      case (state)
        CPU_OWN: begin
          count <= '0;
          if (bus.dma_req) begin
            state   <= DMA_BURST;
            dma_own <= 1'b1;
          end else begin
            state   <= CPU_OWN;
            dma_own <= 1'b0;
          end
        end
        DMA_BURST: begin
          if (bus.dma_req) begin
            if (count == LAST_CNT) begin
              state   <= HANDBACK;
              count   <= '0;
              dma_own <= 1'b0;
            end else begin
              state   <= DMA_BURST;
              count   <= count + 1'b1;
              dma_own <= 1'b1;
            end
          end else begin
            state   <= CPU_OWN;
            count   <= '0;
            dma_own <= 1'b0;
          end
        end
        HANDBACK: begin
          count <= '0;
          if (bus.dma_req) begin
            state   <= DMA_BURST;
            dma_own <= 1'b1;
          end else begin
            state   <= CPU_OWN;
            dma_own <= 1'b0;
          end
        end
        default: begin
          state   <= CPU_OWN;
          count   <= '0;
          dma_own <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    addr_mux  = bus.cpu_address;
    wdata_mux = bus.cpu_data_out;
    we_mux    = bus.cpu_READ_write;
    if (dma_own) begin
      // CPU write strobe is dropped here; the CPU holds it until cpu_rdy returns
      addr_mux  = bus.dma_address;
      wdata_mux = bus.dma_wdata;
      we_mux    = bus.dma_we & bus.dma_req;
    end
  end

  assign bus.mem_address = addr_mux;
  assign bus.mem_data_in = wdata_mux;
  assign bus.mem_wrt_en  = we_mux;
  assign bus.cpu_rdy     = ~dma_own;
  assign bus.dma_ack     = dma_own & bus.dma_req;
  assign bus.cpu_data_in = bus.mem_data_out;
  assign bus.dma_rdata   = bus.mem_data_out;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] mem [0:65535];

  mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_data_out = mem[bus.mem_address];

  always @(posedge clk) begin
    if (bus.mem_wrt_en === 1'b1) mem[bus.mem_address] <= bus.mem_data_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    int i;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

    reset              = 1'b1;
    bus.cpu_address    = 16'h0123;
    bus.cpu_data_out   = 8'h00;
    bus.cpu_READ_write = 1'b0;
    bus.dma_req        = 1'b0;
    bus.dma_address    = 16'h0000;
    bus.dma_wdata      = 8'h00;
    bus.dma_we         = 1'b0;
    tick();
    reset = 1'b0;

    // 1: post-reset state, CPU owns the bus
    settle();
    chk("rst_cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
    chk("rst_dma_ack", 32'(bus.dma_ack), 32'd0);
    chk("rst_wrt_en",  32'(bus.mem_wrt_en), 32'd0);
    chk("rst_addr",    32'(bus.mem_address), 32'h0123);
    bus.cpu_address = 16'h0124;
    bus.cpu_READ_write = 1'b1;
    settle();
    chk("rst_wrt_follow", 32'(bus.mem_wrt_en), 32'd1);
    chk("rst_addr_follow", 32'(bus.mem_address), 32'h0124);
    bus.cpu_READ_write = 1'b0;
    tick();

    // 2: CPU write then read back
    bus.cpu_address = 16'h0200;
    bus.cpu_data_out = 8'h42;
    bus.cpu_READ_write = 1'b1;
    settle();
    chk("cpuw_wrt_en", 32'(bus.mem_wrt_en), 32'd1);
    chk("cpuw_addr",   32'(bus.mem_address), 32'h0200);
    chk("cpuw_data",   32'(bus.mem_data_in), 32'h42);
    tick();
    bus.cpu_READ_write = 1'b0;
    settle();
    chk("cpur_data", 32'(bus.cpu_data_in), 32'h42);
    chk("cpur_rdy",  32'(bus.cpu_rdy), 32'd1);
    bus.cpu_address = 16'h0000;
    tick();

    // 3: continuous DMA writes, burst of 4, handback, burst of 4
    bus.dma_req = 1'b1;
    bus.dma_we = 1'b1;
    bus.dma_address = 16'h0300;
    bus.dma_wdata = 8'h10;
    settle();
    chk("b3_req_seen_ack", 32'(bus.dma_ack), 32'd0);
    chk("b3_req_seen_rdy", 32'(bus.cpu_rdy), 32'd1);
    tick();
    i = 0;
    for (int c = 0; c < 9; c++) begin
      logic exp_ack;
      exp_ack = (c != 4);
      settle();
      chk($sformatf("b3_ack_c%0d", c), 32'(bus.dma_ack), 32'(exp_ack));
      chk($sformatf("b3_rdy_c%0d", c), 32'(bus.cpu_rdy), 32'(!exp_ack));
      if (exp_ack) begin
        chk($sformatf("b3_addr_c%0d", c), 32'(bus.mem_address), 32'(16'h0300 + i));
        chk($sformatf("b3_wdat_c%0d", c), 32'(bus.mem_data_in), 32'(8'h10 + i));
      end
      tick();
      if (exp_ack) begin
        i++;
        bus.dma_address = 16'(16'h0300 + i);
        bus.dma_wdata   = 8'(8'h10 + i);
        if (i == 8) bus.dma_req = 1'b0;
      end
    end
    settle();
    chk("b3_handback_rdy", 32'(bus.cpu_rdy), 32'd1);
    chk("b3_handback_ack", 32'(bus.dma_ack), 32'd0);
    for (int k = 0; k < 8; k++)
      chk($sformatf("b3_mem_%0d", k), 32'(mem[16'h0300 + k]), 32'(8'h10 + k));
    tick();

    // 4: request dropped after 2 acks, then a fresh full burst
    bus.dma_req = 1'b1;
    bus.dma_we = 1'b0;
    bus.dma_address = 16'h0300;
    tick();
    settle();
    chk("b4_ack1", 32'(bus.dma_ack), 32'd1);
    chk("b4_rdata1", 32'(bus.dma_rdata), 32'h10);
    tick();
    bus.dma_address = 16'h0301;
    settle();
    chk("b4_ack2", 32'(bus.dma_ack), 32'd1);
    chk("b4_rdata2", 32'(bus.dma_rdata), 32'h11);
    tick();
    bus.dma_req = 1'b0;
    bus.dma_we = 1'b1;
    settle();
    chk("b4_drop_ack", 32'(bus.dma_ack), 32'd0);
    chk("b4_drop_wrt", 32'(bus.mem_wrt_en), 32'd0);
    chk("b4_drop_rdy", 32'(bus.cpu_rdy), 32'd0);
    tick();
    bus.dma_we = 1'b0;
    settle();
    chk("b4_cpu_own_rdy", 32'(bus.cpu_rdy), 32'd1);
    bus.dma_req = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      settle();
      chk($sformatf("b4_reburst_ack_c%0d", c), 32'(bus.dma_ack), 32'(c < 4));
      chk($sformatf("b4_reburst_rdy_c%0d", c), 32'(bus.cpu_rdy), 32'(c == 4));
      if (c == 4) bus.dma_req = 1'b0;
      tick();
    end

    // 5: reset cuts a burst in its second cycle
    bus.dma_req = 1'b1;
    bus.dma_we = 1'b1;
    bus.dma_address = 16'h0400;
    bus.dma_wdata = 8'hAA;
    tick();
    settle();
    chk("b5_ack1", 32'(bus.dma_ack), 32'd1);
    tick();
    bus.dma_address = 16'h0401;
    bus.dma_wdata = 8'hBB;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("b5_post_rst_rdy", 32'(bus.cpu_rdy), 32'd1);
    chk("b5_post_rst_ack", 32'(bus.dma_ack), 32'd0);
    chk("b5_post_rst_wrt", 32'(bus.mem_wrt_en), 32'd0);
    chk("b5_mem_first", 32'(mem[16'h0400]), 32'hAA);
    bus.dma_req = 1'b0;
    bus.dma_we = 1'b0;
    tick();

    // 6: CPU write held off while DMA reads the same location
    bus.dma_req = 1'b1;
    bus.dma_address = 16'h0300;
    tick();
    bus.cpu_address = 16'h0300;
    bus.cpu_data_out = 8'hFF;
    bus.cpu_READ_write = 1'b1;
    settle();
    chk("b6_ack", 32'(bus.dma_ack), 32'd1);
    chk("b6_rdata", 32'(bus.dma_rdata), 32'h10);
    chk("b6_rdy", 32'(bus.cpu_rdy), 32'd0);
    chk("b6_wrt_blocked", 32'(bus.mem_wrt_en), 32'd0);
    tick();
    bus.dma_req = 1'b0;
    settle();
    chk("b6_stall_rdy", 32'(bus.cpu_rdy), 32'd0);
    chk("b6_stall_wrt", 32'(bus.mem_wrt_en), 32'd0);
    chk("b6_mem_untouched", 32'(mem[16'h0300]), 32'h10);
    tick();
    settle();
    chk("b6_rdy_back", 32'(bus.cpu_rdy), 32'd1);
    chk("b6_wrt_now", 32'(bus.mem_wrt_en), 32'd1);
    tick();
    bus.cpu_READ_write = 1'b0;
    settle();
    chk("b6_mem_ff", 32'(mem[16'h0300]), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
